// File: rtl/aux_native_pkg.sv
// Shared encodings for the AUX native transaction controller: FSM states,
// sink reply codes, final status codes and request commands.
package aux_native_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    WAIT_REPLY,
    GAP,
    DONE
  } state_t;

  localparam logic [1:0] REPLY_ACK   = 2'b00;
  localparam logic [1:0] REPLY_NACK  = 2'b01;
  localparam logic [1:0] REPLY_DEFER = 2'b10;
  localparam logic [1:0] REPLY_RSVD  = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NACK      = 2'b01;
  localparam logic [1:0] ST_EXHAUSTED = 2'b10;
  localparam logic [1:0] ST_PROTO     = 2'b11;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;

  // Largest byte count a single native write may report as accepted.
  localparam logic [7:0] MAX_ACCEPT_M = 8'd15;

  // Number of data bytes in a request; LEN=255 needs the ninth bit.
  function automatic logic [8:0] byte_count(input logic [7:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/aux_reply_timer.sv
// Loadable up-counter with a terminal flag, used both for the reply timeout
// and for the inter-retry gap.
module aux_reply_timer #(
  parameter int W    = 12,
  parameter int TERM = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign term = (cnt == W'(TERM));

endmodule

// File: rtl/aux_native_tr_ctrl.sv
// Native AUX transaction controller: follows one request from encoder TX to
// sink reply, handles DEFER/NACK/timeout retries and reports a final status.
module aux_native_tr_ctrl
  import aux_native_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int MAX_RETRIES    = 7,
  parameter int RETRY_GAP      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de_mux_native_tr_vld,
  input  logic [1:0] de_mux_native_cmd,
  input  logic [7:0] de_mux_native_len,
  input  logic       native_msg_vld,
  input  logic       reply_vld,
  input  logic [1:0] reply_cmd,
  input  logic [7:0] reply_m,
  output logic       ctrl_native_retrans,
  output logic [7:0] ctrl_done_data_number,
  output logic       ctrl_busy,
  output logic       ctrl_done,
  output logic [1:0] ctrl_status,
  output logic [2:0] ctrl_retry_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  state_t     state;
  logic [1:0] cmd_q;
  logic [7:0] len_q;
  logic [8:0] len_p1;
  logic       native_msg_vld_p1;
  logic       msg_fall;
  logic       tmr_term;
  logic       gap_term;

  logic       wr_fin;
  logic       wr_retry;
  logic       wr_done_upd;
  logic [1:0] wr_status;

  assign len_p1   = byte_count(len_q);
  assign msg_fall = native_msg_vld_p1 && !native_msg_vld;

  // Both counters sit at zero outside their state, so entry always starts a fresh count.
  aux_reply_timer #(
    .W    (TMR_W),
    .TERM (TIMEOUT_CYCLES - 1)
  ) u_reply_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != WAIT_REPLY),
    .load_val ('0),
    .en       (1'b1),
    .term     (tmr_term)
  );

  aux_reply_timer #(
    .W    (GAP_W),
    .TERM (RETRY_GAP - 1)
  ) u_gap_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != GAP),
    .load_val ('0),
    .en       (1'b1),
    .term     (gap_term)
  );

  // Reply decode; a reply in the timeout cycle takes precedence over the timeout.
  always_comb begin
    wr_fin      = 1'b0;
    wr_retry    = 1'b0;
    wr_done_upd = 1'b0;
    wr_status   = ST_OK;
    if (reply_vld) begin
      case (reply_cmd)
        REPLY_ACK: begin
          wr_fin = 1'b1;
        end
        REPLY_NACK: begin
          if (cmd_q != CMD_WRITE) begin
            wr_fin    = 1'b1;
            wr_status = ST_NACK;
          end else if (({1'b0, reply_m} > len_p1) || (reply_m > MAX_ACCEPT_M) ||
                       (reply_m < ctrl_done_data_number)) begin
            wr_fin    = 1'b1;
            wr_status = ST_PROTO;
          end else if ({1'b0, reply_m} == len_p1) begin
            wr_fin      = 1'b1;
            wr_done_upd = 1'b1;
          end else begin
            wr_retry    = 1'b1;
            wr_done_upd = 1'b1;
          end
        end
        REPLY_DEFER: begin
          wr_retry = 1'b1;
        end
        default: begin
          wr_fin    = 1'b1;
          wr_status = ST_PROTO;
        end
      endcase
    end else if (tmr_term) begin
      wr_retry = 1'b1;
    end
  end

  // Request attributes are pure data and only meaningful once a request is latched.
  always_ff @(posedge clk) begin
    if (state == IDLE && de_mux_native_tr_vld) begin
      cmd_q <= de_mux_native_cmd;
      len_q <= de_mux_native_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      native_msg_vld_p1     <= 1'b0;
      ctrl_native_retrans   <= 1'b0;
      ctrl_done_data_number <= '0;
      ctrl_busy             <= 1'b0;
      ctrl_done             <= 1'b0;
      ctrl_status           <= ST_OK;
      ctrl_retry_cnt        <= '0;
    end else begin
      native_msg_vld_p1   <= native_msg_vld;
      ctrl_native_retrans <= 1'b0;
      ctrl_done           <= 1'b0;
      case (state)
        IDLE: begin
          if (de_mux_native_tr_vld) begin
            ctrl_retry_cnt        <= '0;
            ctrl_done_data_number <= '0;
            ctrl_status           <= ST_OK;
            ctrl_busy             <= 1'b1;
            state                 <= TX;
          end
        end
        TX: begin
          if (msg_fall) begin
            state <= WAIT_REPLY;
          end
        end
        WAIT_REPLY: begin
          if (wr_done_upd) begin
            ctrl_done_data_number <= reply_m;
          end
          if (wr_fin) begin
            ctrl_status <= wr_status;
            ctrl_done   <= 1'b1;
            state       <= DONE;
          end else if (wr_retry) begin
            if (ctrl_retry_cnt == 3'(MAX_RETRIES)) begin
              ctrl_status <= ST_EXHAUSTED;
              ctrl_done   <= 1'b1;
              state       <= DONE;
            end else begin
              ctrl_retry_cnt <= ctrl_retry_cnt + 3'd1;
              state          <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_term) begin
            ctrl_native_retrans <= 1'b1;
            state               <= TX;
          end
        end
        DONE: begin
          ctrl_busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_native_tr_ctrl.sv
// Directed bench for aux_native_tr_ctrl: stimulus is driven on the falling
// clock edge, outputs are checked there against hand-computed values.
module tb_aux_native_tr_ctrl;
  import aux_native_pkg::*;

  localparam int TIMEOUT_CYCLES = 4000;
  localparam int MAX_RETRIES    = 7;
  localparam int RETRY_GAP      = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_mux_native_tr_vld;
  logic [1:0] de_mux_native_cmd;
  logic [7:0] de_mux_native_len;
  logic       native_msg_vld;
  logic       reply_vld;
  logic [1:0] reply_cmd;
  logic [7:0] reply_m;
  logic       ctrl_native_retrans;
  logic [7:0] ctrl_done_data_number;
  logic       ctrl_busy;
  logic       ctrl_done;
  logic [1:0] ctrl_status;
  logic [2:0] ctrl_retry_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int retrans_seen = 0;
  int done_seen    = 0;

  aux_native_tr_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES),
    .RETRY_GAP      (RETRY_GAP)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .de_mux_native_tr_vld  (de_mux_native_tr_vld),
    .de_mux_native_cmd     (de_mux_native_cmd),
    .de_mux_native_len     (de_mux_native_len),
    .native_msg_vld        (native_msg_vld),
    .reply_vld             (reply_vld),
    .reply_cmd             (reply_cmd),
    .reply_m               (reply_m),
    .ctrl_native_retrans   (ctrl_native_retrans),
    .ctrl_done_data_number (ctrl_done_data_number),
    .ctrl_busy             (ctrl_busy),
    .ctrl_done             (ctrl_done),
    .ctrl_status           (ctrl_status),
    .ctrl_retry_cnt        (ctrl_retry_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ctrl_native_retrans) retrans_seen <= retrans_seen + 1;
    if (ctrl_done)           done_seen    <= done_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_req(input logic [1:0] c, input logic [7:0] l);
    de_mux_native_tr_vld = 1'b1;
    de_mux_native_cmd    = c;
    de_mux_native_len    = l;
    @(negedge clk);
    de_mux_native_tr_vld = 1'b0;
  endtask

  // Returns on the first falling edge after the controller has seen the end of TX.
  task automatic send_msg(input int n);
    native_msg_vld = 1'b1;
    step(n);
    native_msg_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_reply(input logic [1:0] c, input logic [7:0] m);
    reply_vld = 1'b1;
    reply_cmd = c;
    reply_m   = m;
    @(negedge clk);
    reply_vld = 1'b0;
  endtask

  // Called right after send_reply: the pulse must appear RETRY_GAP+1 cycles after the strobe.
  task automatic expect_retrans(input string tag);
    step(RETRY_GAP - 1);
    chk({tag, "_early"}, ctrl_native_retrans, 1'b0);
    step(1);
    chk({tag, "_pulse"}, ctrl_native_retrans, 1'b1);
  endtask

  task automatic wait_evt(input int budget, output int elapsed);
    elapsed = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ctrl_native_retrans || ctrl_done) begin
        elapsed = i;
        break;
      end
    end
  endtask

  initial begin
    int base_r;
    int base_d;
    int el;

    rst_n = 1'b0;
    de_mux_native_tr_vld = 1'b0;
    de_mux_native_cmd = 2'b00;
    de_mux_native_len = 8'd0;
    native_msg_vld = 1'b0;
    reply_vld = 1'b0;
    reply_cmd = 2'b00;
    reply_m = 8'd0;
    step(2);
    chk("rst_busy", ctrl_busy, 1'b0);
    chk("rst_flags", {ctrl_done, ctrl_native_retrans}, 2'b00);
    chk("rst_regs", {ctrl_status, ctrl_retry_cnt, ctrl_done_data_number}, 13'd0);
    rst_n = 1'b1;
    step(1);

    // Write LEN=3, ACK about 20 cycles after end of TX
    base_r = retrans_seen;
    start_req(CMD_WRITE, 8'd3);
    chk("t1_busy", ctrl_busy, 1'b1);
    send_msg(4);
    step(19);
    send_reply(REPLY_ACK, 8'd0);
    chk("t1_done", {ctrl_done, ctrl_busy}, 2'b11);
    chk("t1_status", {ctrl_status, ctrl_retry_cnt}, {ST_OK, 3'd0});
    step(1);
    chk("t1_idle", {ctrl_done, ctrl_busy}, 2'b00);
    chk("t1_noretrans", retrans_seen - base_r, 0);

    // Reply outside WAIT_REPLY is ignored
    send_reply(REPLY_NACK, 8'd0);
    step(1);
    chk("idle_reply", {ctrl_done, ctrl_busy, ctrl_status}, {2'b00, ST_OK});

    // Read, DEFER twice, then ACK
    start_req(CMD_READ, 8'd0);
    send_msg(4);
    step(10);
    send_reply(REPLY_DEFER, 8'd0);
    expect_retrans("t2_r1");
    chk("t2_cnt1", ctrl_retry_cnt, 3'd1);
    send_msg(4);
    step(5);
    send_reply(REPLY_DEFER, 8'd0);
    expect_retrans("t2_r2");
    send_msg(4);
    step(3);
    send_reply(REPLY_ACK, 8'd0);
    chk("t2_done", ctrl_done, 1'b1);
    chk("t2_final", {ctrl_status, ctrl_retry_cnt, ctrl_done_data_number}, {ST_OK, 3'd2, 8'd0});
    step(1);

    // Write LEN=7, partial NACK M=3, then NACK M=8 completes
    start_req(CMD_WRITE, 8'd7);
    send_msg(11);
    step(5);
    send_reply(REPLY_NACK, 8'd3);
    chk("t3_dn_gap", ctrl_done_data_number, 8'd3);
    expect_retrans("t3_r1");
    chk("t3_dn_pulse", ctrl_done_data_number, 8'd3);
    send_msg(11);
    chk("t3_dn_tx", ctrl_done_data_number, 8'd3);
    step(5);
    send_reply(REPLY_NACK, 8'd8);
    chk("t3_done", ctrl_done, 1'b1);
    chk("t3_final", {ctrl_status, ctrl_retry_cnt, ctrl_done_data_number}, {ST_OK, 3'd1, 8'd8});
    step(1);

    // Reply and timeout in the same cycle: the reply wins
    start_req(CMD_READ, 8'd0);
    send_msg(4);
    step(TIMEOUT_CYCLES - 1);
    send_reply(REPLY_ACK, 8'd0);
    chk("tie_done", ctrl_done, 1'b1);
    chk("tie_status", {ctrl_status, ctrl_retry_cnt}, {ST_OK, 3'd0});
    step(1);

    // Read with no reply: 7 timeouts retransmit, the 8th exhausts
    base_r = retrans_seen;
    start_req(CMD_READ, 8'd0);
    for (int i = 0; i <= MAX_RETRIES; i++) begin
      send_msg(4);
      wait_evt(TIMEOUT_CYCLES + RETRY_GAP + 50, el);
      chk("t4_evt", {ctrl_native_retrans, ctrl_done}, (i < MAX_RETRIES) ? 2'b10 : 2'b01);
      if (i == 0) chk("t4_lat_first", el, TIMEOUT_CYCLES + RETRY_GAP);
      if (i == MAX_RETRIES) chk("t4_lat_last", el, TIMEOUT_CYCLES);
    end
    chk("t4_final", {ctrl_status, ctrl_retry_cnt}, {ST_EXHAUSTED, 3'd7});
    step(2);
    chk("t4_pulses", retrans_seen - base_r, MAX_RETRIES);

    // Write LEN=3, NACK M=9 exceeds request: protocol error, no retransmission
    base_r = retrans_seen;
    start_req(CMD_WRITE, 8'd3);
    chk("t5_status_clr", {ctrl_status, ctrl_retry_cnt}, {ST_OK, 3'd0});
    send_msg(5);
    step(2);
    send_reply(REPLY_NACK, 8'd9);
    chk("t5_done", ctrl_done, 1'b1);
    chk("t5_status", ctrl_status, ST_PROTO);
    step(RETRY_GAP + 3);
    chk("t5_noretrans", retrans_seen - base_r, 0);

    // Read NACK
    start_req(CMD_READ, 8'd0);
    send_msg(4);
    send_reply(REPLY_NACK, 8'd0);
    chk("t5b_done", {ctrl_done, ctrl_status}, {1'b1, ST_NACK});
    step(1);

    // Reserved reply code
    start_req(CMD_WRITE, 8'd0);
    send_msg(3);
    send_reply(REPLY_RSVD, 8'd0);
    chk("rsvd_status", {ctrl_done, ctrl_status}, {1'b1, ST_PROTO});
    step(1);

    // Partial write NACK M=2 then smaller M=1 is a protocol error
    start_req(CMD_WRITE, 8'd7);
    send_msg(4);
    send_reply(REPLY_NACK, 8'd2);
    expect_retrans("dec_r1");
    send_msg(4);
    send_reply(REPLY_NACK, 8'd1);
    chk("dec_status", {ctrl_done, ctrl_status, ctrl_done_data_number}, {1'b1, ST_PROTO, 8'd2});
    step(1);

    // Asynchronous reset while waiting for a reply
    start_req(CMD_WRITE, 8'd3);
    send_msg(4);
    step(5);
    base_d = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", ctrl_busy, 1'b0);
    chk("ar_outs", {ctrl_done, ctrl_native_retrans, ctrl_status, ctrl_retry_cnt, ctrl_done_data_number},
        15'd0);
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("ar_nodone", done_seen - base_d, 0);
    start_req(CMD_READ, 8'd0);
    chk("ar_restart", ctrl_busy, 1'b1);
    send_msg(4);
    send_reply(REPLY_ACK, 8'd0);
    chk("ar_final", {ctrl_done, ctrl_status, ctrl_retry_cnt}, {1'b1, ST_OK, 3'd0});
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aux_native_tr_ctrl.md
Name: aux_native_tr_ctrl

Overview:
Transaction controller for the AUX native path. It tracks each native request from the de-mux through the native message encoder and the sink reply. It drives the encoder's retransmission interface (ctrl_native_retrans, ctrl_done_data_number) and enforces the reply timeout, the retry limit and the inter-retry gap. It reports a final status per transaction to the link-layer policy maker.

Parameters:
TIMEOUT_CYCLES, 4000, clk cycles to wait for a reply after the request ends (400 us at 10 MHz)
MAX_RETRIES, 7, maximum retransmissions per transaction (DEFER, timeout or partial NACK)
RETRY_GAP, 16, idle clk cycles between reply/timeout and the retransmission pulse

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
de_mux_native_tr_vld  in  1  new native request accepted (same strobe the encoder uses)
de_mux_native_cmd  in  2  00 write, 01 read
de_mux_native_len  in  8  LEN field (data bytes minus 1)
native_msg_vld  in  1  encoder output-valid; its falling edge marks end of request TX
reply_vld  in  1  one-cycle strobe: decoded sink reply available
reply_cmd  in  2  00 ACK, 01 NACK, 10 DEFER, 11 reserved
reply_m  in  8  bytes written, valid with write NACK
ctrl_native_retrans  out  1  one-cycle pulse to the encoder
ctrl_done_data_number  out  8  bytes already accepted; stable from the pulse until the next tr_vld
ctrl_busy  out  1  transaction in flight
ctrl_done  out  1  one-cycle pulse at transaction end
ctrl_status  out  2  00 OK, 01 NACK, 10 RETRY_EXHAUSTED, 11 PROTO_ERR; held until the next accepted request
ctrl_retry_cnt  out  3  retries used by the current/last transaction

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs are 0.
  - State is IDLE; timer, gap and retry counters are 0.
  - A reset mid-transaction abandons it with no ctrl_done.
- State IDLE:
  - On de_mux_native_tr_vld: latch cmd and len, clear retry_cnt, ctrl_done_data_number and ctrl_status.
  - Set ctrl_busy on the next edge; go to TX.
- State TX:
  - Track native_msg_vld with a 1-cycle delay.
  - native_msg_vld 1->0 goes to WAIT_REPLY; the timer loads 0.
- State WAIT_REPLY: the timer increments each cycle. Events are evaluated in priority order:
  1. ACK: status OK -> DONE.
  2. NACK on a read: status NACK -> DONE.
  3. NACK on a write:
     - reply_m > len+1, or reply_m > 15: PROTO_ERR -> DONE.
     - reply_m == len+1: status OK -> DONE (all bytes accepted).
     - Otherwise: retry with done = reply_m.
  4. DEFER: retry; done is unchanged.
  5. Reserved code: PROTO_ERR -> DONE.
  6. Timer reaches TIMEOUT_CYCLES-1 with no reply: retry; done is unchanged.
  - reply_vld and timeout in the same cycle: the reply wins.
- Retry rule:
  - retry_cnt == MAX_RETRIES: RETRY_EXHAUSTED -> DONE.
  - Otherwise: retry_cnt++, load the gap counter, go to GAP.
- State GAP: after RETRY_GAP cycles, pulse ctrl_native_retrans for exactly 1 cycle; go to TX.
  - Retransmit latency: reply strobe to pulse = RETRY_GAP+1 cycles.
- State DONE (1 cycle):
  - ctrl_done = 1; ctrl_busy deasserts on the next edge; go to IDLE.
- ctrl_done_data_number is cumulative:
  - Each write NACK replaces it with reply_m; it is never decremented.
  - reply_m < current value: PROTO_ERR -> DONE.
- Ignored inputs:
  - de_mux_native_tr_vld while ctrl_busy (the upstream must hold off).
  - reply_vld outside WAIT_REPLY.
- Arithmetic:
  - len+1 is computed at 9 bits.
  - Timer width is $clog2(TIMEOUT_CYCLES); retry counter is 3 bits; saturation is not needed.

Decomposition:
- Package aux_native_pkg:
  - state enum {IDLE, TX, WAIT_REPLY, GAP, DONE}
  - reply codes REPLY_ACK/NACK/DEFER
  - status codes ST_OK/ST_NACK/ST_EXHAUSTED/ST_PROTO
  - CMD_WRITE/CMD_READ
- Sub-module aux_reply_timer: loadable up-counter with a terminal pulse, reused for the reply timeout and the gap count.

Test Plan:
- Write LEN=3, ACK 20 cycles after native_msg_vld falls -> no retrans, ctrl_done with status 00, retry_cnt 0.
- Read, DEFER twice then ACK -> two retrans pulses each RETRY_GAP+1 cycles after the reply, done_data_number 0, retry_cnt 2, status 00.
- Write LEN=7, NACK M=3 -> one retrans pulse with done_data_number=3 held stable; then NACK M=8 -> status 00.
- Read, no reply ever -> 7 retrans pulses spaced TIMEOUT_CYCLES+RETRY_GAP+~TX; 8th timeout -> status 10, retry_cnt 7.
- Write LEN=3, NACK M=9 -> status 11 with no retrans; read NACK -> status 01.
- rst_n low during WAIT_REPLY -> all outputs 0 immediately, no ctrl_done; a new tr_vld after release starts cleanly.
